unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port 16-bit memory between two requesters: the instruction-fetch stage (read-only) and the memory-access stage (read/write).
- Sits between the core's instruction-memory and main-memory ports and the external memory.
- Sequences one transaction at a time with a req/ack handshake, data-stage priority, fetch anti-starvation and a timeout abort.
- Provides stall indications back to the pipeline.

Parameters:
- ADDR_WIDTH, 16, address width of both requesters and memory port.
- DATA_WIDTH, 16, data width.
- MAX_MA_STREAK, 4, consecutive contended MA grants allowed before IF is forced.
- TIMEOUT_CYCLES, 255, BUSY cycles without mem_ready before abort; must be ≥1.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request; held with if_addr until if_ack.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DATA_WIDTH  fetched instruction; held until next IF completion.
- ma_req  in  1  data request; held with ma_we/ma_addr/ma_wdata until ma_ack.
- ma_we  in  1  1 = write, 0 = read.
- ma_addr  in  ADDR_WIDTH  data address.
- ma_wdata  in  DATA_WIDTH  store data.
- ma_ack  out  1  one-cycle pulse: data transaction complete.
- ma_rdata  out  DATA_WIDTH  load data; updated only on read completion.
- mem_req  out  1  memory transaction active.
- mem_we  out  1  memory write enable, valid while mem_req.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ready  in  1  memory completes the current transaction this cycle.
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ready.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_ma  out  1  ma_req & ~ma_ack (combinational).
- bus_error  out  1  one-cycle pulse coincident with a timeout-abort ack.

Behaviour:

Reset (asynchronous, active-high):
- All registered outputs go to 0: mem_req, mem_we, mem_addr, mem_wdata, if_ack, ma_ack, if_rdata, ma_rdata, bus_error.
- State goes to IDLE; streak and timeout counters go to 0.
- Reset mid-transaction aborts immediately, with no ack issued. Requesters re-issue after reset.

State machine:
- States: IDLE, BUSY_IF, BUSY_MA.

IDLE:
- Eligible requests are a requester's req with its ack low this cycle. A requester acked this cycle is masked.
- Only one eligible: grant it.
- Both eligible: grant MA if streak < MAX_MA_STREAK, else grant IF.
- On grant edge:
  - Latch addr, we and wdata into mem_* registers (IF grant forces we = 0).
  - Set mem_req = 1, go to BUSY_x, clear timeout counter.
- Streak update:
  - MA grant with if_req high: streak+1, saturating at MAX_MA_STREAK.
  - MA grant with if_req low: streak = 0.
  - IF grant: streak = 0.

BUSY_x:
- mem_* held constant.
- If mem_ready is sampled 1 on an edge:
  - mem_req goes to 0 and the FSM returns to IDLE.
  - The granted ack pulses for the next cycle.
  - For an IF read or MA read, mem_rdata is captured into if_rdata or ma_rdata.
  - For an MA write, ma_rdata is unchanged.
- Otherwise the timeout counter increments.
- Timeout abort: on the edge where the counter reaches TIMEOUT_CYCLES with mem_ready still 0:
  - mem_req goes to 0 and the FSM returns to IDLE.
  - The granted ack and bus_error pulse together.
  - Captured rdata is forced to 0. Any write is considered lost.

Timing and handshake rules:
- mem_ready outside BUSY is ignored.
- Latency: request seen in IDLE at cycle t; mem_req high at t+1. If mem_ready is high at t+1, ack is high at t+2. Minimum latency is 2 cycles.
- Back-to-back throughput: one transaction per 2 cycles, because the IDLE cycle coincides with the ack cycle.
- A requester dropping req while BUSY on its behalf is illegal (undefined). Dropping req while not granted is legal.
- Only one ack is ever high in a cycle. An ack is never issued without a prior grant.

Decomposition:
- Shared package core_mem_pkg holds:
  - state enum (IDLE, BUSY_IF, BUSY_MA);
  - grant-owner constants (GNT_IF, GNT_MA);
  - ADDR_WIDTH/DATA_WIDTH defaults.
- One sub-module, mem_arb_timer:
  - clearable, saturating BUSY-cycle counter with a terminal-count output;
  - parameterised by TIMEOUT_CYCLES.
- Arbitration, streak counter and FSM stay in the top module.

Test Plan:
1. IF alone: if_req=1, if_addr=0x0040, mem_ready=1 the cycle after mem_req rises, mem_rdata=0xA123 -> mem_req with mem_addr=0x0040, mem_we=0; if_ack pulses at t+2 with if_rdata=0xA123.
2. Simultaneous if_req and ma_req (write, ma_addr=0x1000, ma_wdata=0xBEEF) -> MA granted first: mem_we=1, mem_wdata=0xBEEF, ma_ack pulses. IF then granted in the IDLE after the ack cycle (ma_req dropped); ma_rdata unchanged.
3. ma_req held continuously with fresh requests and if_req held, MAX_MA_STREAK=4 -> exactly 4 MA grants, then one IF grant, then streak restarts at 0.
4. Grant MA read, hold mem_ready=0 with TIMEOUT_CYCLES=8 -> ma_ack and bus_error pulse together after 8 BUSY cycles, ma_rdata=0x0000, FSM back in IDLE.
5. Assert reset mid-BUSY_IF with mem_req=1 -> mem_req, acks and rdata go to 0 asynchronously before the next edge; no if_ack after reset release until a new grant completes.
6. Memory stretched 3 cycles (mem_ready low for 2 BUSY cycles) -> mem_addr/mem_wdata/mem_we stable throughout BUSY; stall_ma=1 every cycle until ma_ack.

Source files
------------

// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared state, grant-owner and width definitions for the memory arbiter
package core_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MA} state_t;
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_MA = 1'b1;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: clearable saturating busy-cycle counter flagging the cycle whose edge reaches the limit
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  // count enabled cycles, holding at the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != W'(TIMEOUT_CYCLES)) cnt <= cnt + W'(1);
  end
  assign tc = en && (cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch and data-access requesters
module unified_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_MA_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ma_req,
  input  logic                  ma_we,
  input  logic [ADDR_WIDTH-1:0] ma_addr,
  input  logic [DATA_WIDTH-1:0] ma_wdata,
  output logic                  ma_ack,
  output logic [DATA_WIDTH-1:0] ma_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall_if,
  output logic                  stall_ma,
  output logic                  bus_error
);
  localparam int SW = $clog2(MAX_MA_STREAK + 1);
  state_t state;
  logic [SW-1:0] streak;
  logic if_elig, ma_elig, gnt, grant, busy, tc;
  // eligibility masks a requester acked this cycle; MA wins contention until its streak is used up
  always_comb begin
    if_elig = if_req & ~if_ack;
    ma_elig = ma_req & ~ma_ack;
    gnt = (ma_elig & (~if_elig | (streak < SW'(MAX_MA_STREAK)))) ? GNT_MA : GNT_IF;
    grant = (state == IDLE) & (if_elig | ma_elig);
    busy = state != IDLE;
  end
  assign stall_if = if_req & ~if_ack;
  assign stall_ma = ma_req & ~ma_ack;
  mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr(~busy),
    .en(busy & ~mem_ready),
    .tc(tc)
  );
  // grant in IDLE, hold the memory port while busy, finish on ready or timeout abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      streak <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_ack <= 1'b0;
      ma_ack <= 1'b0;
      if_rdata <= '0;
      ma_rdata <= '0;
      bus_error <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      ma_ack <= 1'b0;
      bus_error <= 1'b0;
      if (grant) begin
        mem_req <= 1'b1;
        mem_addr <= (gnt == GNT_MA) ? ma_addr : if_addr;
        mem_we <= (gnt == GNT_MA) & ma_we;
        mem_wdata <= (gnt == GNT_MA) ? ma_wdata : '0;
        state <= (gnt == GNT_MA) ? BUSY_MA : BUSY_IF;
        streak <= ((gnt == GNT_MA) && if_req) ? ((streak == SW'(MAX_MA_STREAK)) ? streak : streak + SW'(1)) : '0;
      end else if (busy && (mem_ready || tc)) begin
        mem_req <= 1'b0;
        state <= IDLE;
        bus_error <= ~mem_ready;
        if (state == BUSY_IF) begin
          if_ack <= 1'b1;
          if_rdata <= mem_ready ? mem_rdata : '0;
        end else begin
          ma_ack <= 1'b1;
          if (!mem_we) ma_rdata <= mem_ready ? mem_rdata : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scenario checks for the unified memory arbiter
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic if_req, ma_req, ma_we, mem_ready;
  logic [15:0] if_addr, ma_addr, ma_wdata, mem_rdata;
  logic if_ack, ma_ack, mem_req, mem_we, stall_if, stall_ma, bus_error;
  logic [15:0] if_rdata, ma_rdata, mem_addr, mem_wdata;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_MA_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_ack(ma_ack), .ma_rdata(ma_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_ma(stall_ma), .bus_error(bus_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_req = 0; ma_req = 0; ma_we = 0; mem_ready = 0;
    if_addr = 0; ma_addr = 0; ma_wdata = 0; mem_rdata = 0;
    step();
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0h exp 0", mem_req); end
    checks++; if ({if_ack, ma_ack, bus_error} !== 3'b000) begin errors++; $display("FAIL rst_acks got %b exp 000", {if_ack, ma_ack, bus_error}); end
    checks++; if ({if_rdata, ma_rdata, mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL rst_regs got %h exp 0", {if_rdata, ma_rdata, mem_addr, mem_wdata}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_if_alone();
    if_req = 1; if_addr = 16'h0040;
    step();
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'h0040}) begin errors++; $display("FAIL if_grant got %b %b %h exp 1 0 0040", mem_req, mem_we, mem_addr); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL if_stall got %0h exp 1", stall_if); end
    mem_ready = 1; mem_rdata = 16'hA123;
    step();
    checks++; if ({if_ack, if_rdata} !== {1'b1, 16'hA123}) begin errors++; $display("FAIL if_ack got %b %h exp 1 a123", if_ack, if_rdata); end
    checks++; if ({mem_req, stall_if, ma_ack} !== 3'b000) begin errors++; $display("FAIL if_done got %b exp 000", {mem_req, stall_if, ma_ack}); end
    if_req = 0; mem_ready = 0;
    step();
    checks++; if ({if_ack, mem_req} !== 2'b00) begin errors++; $display("FAIL if_idle got %b exp 00", {if_ack, mem_req}); end
  endtask

  task automatic test_stretch();
    ma_req = 1; ma_we = 0; ma_addr = 16'h2002; ma_wdata = 16'h1111;
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin mem_ready = 1; mem_rdata = 16'h1234; end
      checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b10, 16'h2002, 16'h1111}) begin errors++; $display("FAIL st_hold%0d got %b %b %h %h", i, mem_req, mem_we, mem_addr, mem_wdata); end
      checks++; if ({stall_ma, ma_ack} !== 2'b10) begin errors++; $display("FAIL st_stall%0d got %b exp 10", i, {stall_ma, ma_ack}); end
      step();
    end
    checks++; if ({ma_ack, ma_rdata, stall_ma, bus_error} !== {1'b1, 16'h1234, 2'b00}) begin errors++; $display("FAIL st_ack got %b %h %b %b", ma_ack, ma_rdata, stall_ma, bus_error); end
    ma_req = 0; mem_ready = 0;
    step();
  endtask

  task automatic test_contention();
    if_req = 1; if_addr = 16'h0080;
    ma_req = 1; ma_we = 1; ma_addr = 16'h1000; ma_wdata = 16'hBEEF;
    step();
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h1000, 16'hBEEF}) begin errors++; $display("FAIL ct_ma got %b %b %h %h", mem_req, mem_we, mem_addr, mem_wdata); end
    mem_ready = 1; mem_rdata = 16'h5555;
    step();
    checks++; if ({ma_ack, if_ack, ma_rdata} !== {2'b10, 16'h1234}) begin errors++; $display("FAIL ct_ack got %b %b %h exp 1 0 1234", ma_ack, if_ack, ma_rdata); end
    ma_req = 0; mem_ready = 0;
    step();
    checks++; if ({mem_req, mem_we, mem_addr, ma_ack} !== {2'b10, 16'h0080, 1'b0}) begin errors++; $display("FAIL ct_if got %b %b %h %b", mem_req, mem_we, mem_addr, ma_ack); end
    mem_ready = 1; mem_rdata = 16'h7777;
    step();
    checks++; if ({if_ack, if_rdata, ma_rdata} !== {1'b1, 16'h7777, 16'h1234}) begin errors++; $display("FAIL ct_ifack got %b %h %h", if_ack, if_rdata, ma_rdata); end
    if_req = 0; mem_ready = 0;
    step();
  endtask

  task automatic test_streak();
    logic [15:0] a;
    for (int r = 0; r < 6; r++) begin
      a = (r == 5) ? 16'h3010 : 16'h3000 + 16'(r);
      if_req = 1; if_addr = 16'h0300;
      ma_req = 1; ma_we = 1; ma_addr = a; ma_wdata = 16'(r);
      step();
      if (r == 4) begin
        checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'h0300}) begin errors++; $display("FAIL sk_if got %b %b %h exp 1 0 0300", mem_req, mem_we, mem_addr); end
        mem_ready = 1; mem_rdata = 16'h0F0F;
        step();
        checks++; if ({if_ack, if_rdata} !== {1'b1, 16'h0F0F}) begin errors++; $display("FAIL sk_ifack got %b %h", if_ack, if_rdata); end
      end else begin
        checks++; if ({mem_req, mem_we, mem_addr} !== {2'b11, a}) begin errors++; $display("FAIL sk_ma%0d got %b %b %h exp 1 1 %h", r, mem_req, mem_we, mem_addr, a); end
        if_req = 0; mem_ready = 1;
        step();
        checks++; if (ma_ack !== 1'b1) begin errors++; $display("FAIL sk_ack%0d got %0h exp 1", r, ma_ack); end
      end
      if_req = 0; ma_req = 0; mem_ready = 0;
      step();
    end
  endtask

  task automatic test_timeout();
    ma_req = 1; ma_we = 0; ma_addr = 16'h4000; mem_rdata = 16'hDEAD;
    step();
    for (int i = 1; i < 8; i++) begin
      step();
      checks++; if ({mem_req, ma_ack, bus_error} !== 3'b100) begin errors++; $display("FAIL to_wait%0d got %b exp 100", i, {mem_req, ma_ack, bus_error}); end
    end
    step();
    checks++; if ({ma_ack, bus_error, ma_rdata, mem_req} !== {2'b11, 16'h0000, 1'b0}) begin errors++; $display("FAIL to_abort got %b %b %h %b", ma_ack, bus_error, ma_rdata, mem_req); end
    ma_req = 0;
    step();
    checks++; if ({mem_req, ma_ack, bus_error} !== 3'b000) begin errors++; $display("FAIL to_idle got %b exp 000", {mem_req, ma_ack, bus_error}); end
  endtask

  task automatic test_reset_mid();
    if_req = 1; if_addr = 16'h0500;
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_busy got %0h exp 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({mem_req, if_ack, ma_ack, if_rdata} !== {3'b000, 16'h0000}) begin errors++; $display("FAIL rm_async got %b %b %b %h", mem_req, if_ack, ma_ack, if_rdata); end
    step();
    reset = 1'b0; mem_ready = 1; mem_rdata = 16'h5A5A;
    checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL rm_noack got %0h exp 0", if_ack); end
    step();
    checks++; if ({mem_req, mem_addr, if_ack} !== {1'b1, 16'h0500, 1'b0}) begin errors++; $display("FAIL rm_regrant got %b %h %b", mem_req, mem_addr, if_ack); end
    step();
    checks++; if ({if_ack, if_rdata} !== {1'b1, 16'h5A5A}) begin errors++; $display("FAIL rm_ack got %b %h", if_ack, if_rdata); end
    if_req = 0; mem_ready = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_if_alone();
    test_stretch();
    test_contention();
    test_streak();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
